alu_seq_unit: RTL and testbench

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_nibble_adder.sv | 34 +++
 rtl/alu_seq_unit.sv | 178 +++++++++++++++++
 tb/tb_alu_seq_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes, FSM state encoding and BCD correction constants for alu_seq_unit
package alu_seq_pkg;

    localparam logic [3:0] OP_ORA = 4'h0;
    localparam logic [3:0] OP_AND = 4'h1;
    localparam logic [3:0] OP_EOR = 4'h2;
    localparam logic [3:0] OP_ADC = 4'h3;
    localparam logic [3:0] OP_SBC = 4'h4;
    localparam logic [3:0] OP_ROR = 4'h5;
    localparam logic [3:0] OP_TST = 4'h6;
    localparam logic [3:0] OP_PSA = 4'h7;
    localparam logic [3:0] OP_MUL = 4'h8;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE    = 1'b0;
    localparam state_t ST_MUL_RUN = 1'b1;

    localparam logic [4:0] DEC_MAX_DIGIT = 5'd9;
    localparam logic [4:0] DEC_ADJ_ADD   = 5'd6;
    localparam logic [4:0] DEC_ADJ_SUB   = 5'd10;

endpackage

// File: rtl/alu_nibble_adder.sv
// rtl/alu_nibble_adder.sv - one 4-bit slice of the ripple adder with optional BCD correction
module alu_nibble_adder
    import alu_seq_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    input  logic       dec,
    input  logic       sub,
    output logic [3:0] digit,
    output logic       cout,
    output logic       raw_cout
);

    logic [4:0] s;

    assign s        = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    assign raw_cout = s[4];

    // Decimal correction: add-side adjusts any sum above 9, subtract-side
    // adjusts when the slice borrowed (raw carry clear); digits 10-15 fall
    // through the same arithmetic without special handling.
    always_comb begin
        digit = s[3:0];
        cout  = s[4];
        if (dec && !sub && (s > DEC_MAX_DIGIT)) begin
            cout  = 1'b1;
            digit = s[3:0] + DEC_ADJ_ADD[3:0];
        end else if (dec && sub && !s[4]) begin
            digit = s[3:0] + DEC_ADJ_SUB[3:0];
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - registered ALU with BCD add/sub and optional shift-add multiplier (ALU_SEQ_MUL_EN)
module alu_seq_unit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             dec,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_out_hi,
    output logic             carry_out,
    output logic             half_carry_out,
    output logic             overflow_out,
    output logic             zero_out
);

    logic             is_sbc;
    logic [WIDTH-1:0] b_eff;
    logic [NIBBLES:0] chain;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] bin_sum;
    logic             add_ovf;

    assign is_sbc = (op == OP_SBC);
    assign b_eff  = is_sbc ? ~b : b;
    assign chain[0] = c_in;

    for (genvar g = 0; g < NIBBLES; g++) begin : g_nib
        logic nib_cout;
        logic nib_raw;

        alu_nibble_adder u_nib (
            .x        (a[4*g +: 4]),
            .y        (b_eff[4*g +: 4]),
            .cin      (chain[g]),
            .dec      (dec),
            .sub      (is_sbc),
            .digit    (add_res[4*g +: 4]),
            .cout     (nib_cout),
            .raw_cout (nib_raw)
        );

        // Binary mode ripples the plain carry; decimal mode ripples the adjusted one.
        assign chain[g+1] = dec ? nib_cout : nib_raw;
    end

    // Overflow is judged on the binary sum, before any decimal adjustment.
    assign bin_sum = a + b_eff + {{(WIDTH-1){1'b0}}, c_in};
    assign add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (bin_sum[WIDTH-1] != a[WIDTH-1]);

    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_h;
    logic             res_v;

    // Single-cycle result selection; unknown codes (and MUL without the multiplier) pass a.
    always_comb begin
        res   = a;
        res_c = 1'b0;
        res_h = 1'b0;
        res_v = 1'b0;
        case (op)
            OP_ORA: res = a | b;
            OP_AND: begin
                res   = a & b;
                res_c = |(a & b);
            end
            OP_EOR: res = a ^ b;
            OP_TST: res = ~a & b;
            OP_ROR: begin
                res   = {c_in, a[WIDTH-1:1]};
                res_c = a[0];
            end
            OP_ADC, OP_SBC: begin
                res   = add_res;
                res_c = chain[NIBBLES];
                res_h = chain[1];
                res_v = add_ovf;
            end
            default: res = a;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             state;
    logic               busy_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_next;

    // Upper half accumulates the multiplicand when the current multiplier bit is set, then shifts right.
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign prod_next = {mul_sum, prod[WIDTH-1:1]};
    assign busy       = busy_r;
    assign alu_out_hi = hi_r;
`else
    assign busy       = 1'b0;
    assign alu_out_hi = {WIDTH{1'b0}};
`endif

    // Request acceptance, multiplier iteration and result/flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done           <= 1'b0;
            alu_out        <= '0;
            carry_out      <= 1'b0;
            half_carry_out <= 1'b0;
            overflow_out   <= 1'b0;
            zero_out       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            hi_r   <= '0;
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            if (state == ST_MUL_RUN) begin
                prod <= prod_next;
                cnt  <= cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state          <= ST_IDLE;
                    busy_r         <= 1'b0;
                    cnt            <= '0;
                    done           <= 1'b1;
                    alu_out        <= prod_next[WIDTH-1:0];
                    hi_r           <= prod_next[2*WIDTH-1:WIDTH];
                    carry_out      <= |prod_next[2*WIDTH-1:WIDTH];
                    half_carry_out <= 1'b0;
                    overflow_out   <= 1'b0;
                    zero_out       <= (prod_next == '0);
                end
            end else
`endif
            if (start) begin
`ifdef ALU_SEQ_MUL_EN
                if (op == OP_MUL) begin
                    state  <= ST_MUL_RUN;
                    busy_r <= 1'b1;
                    mcand  <= a;
                    prod   <= {{WIDTH{1'b0}}, b};
                    cnt    <= '0;
                end else
`endif
                begin
                    done           <= 1'b1;
                    alu_out        <= res;
                    carry_out      <= res_c;
                    half_carry_out <= res_h;
                    overflow_out   <= res_v;
                    zero_out       <= (res == '0);
`ifdef ALU_SEQ_MUL_EN
                    hi_r           <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - directed self-checking bench for alu_seq_unit (8-bit and 16-bit instances)
module tb_alu_seq_unit;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start;
    logic [3:0]  op;
    logic [7:0]  a, b;
    logic        c_in, dec;
    logic        busy, done;
    logic [7:0]  alu_out, alu_out_hi;
    logic        carry_out, half_carry_out, overflow_out, zero_out;

    logic        start_w;
    logic [3:0]  op_w;
    logic [15:0] a_w, b_w;
    logic        c_in_w, dec_w;
    logic        busy_w, done_w;
    logic [15:0] alu_out_w, alu_out_hi_w;
    logic        carry_out_w, half_carry_out_w, overflow_out_w, zero_out_w;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .c_in(c_in), .dec(dec), .busy(busy), .done(done), .alu_out(alu_out),
        .alu_out_hi(alu_out_hi), .carry_out(carry_out), .half_carry_out(half_carry_out),
        .overflow_out(overflow_out), .zero_out(zero_out)
    );

    alu_seq_unit #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .start(start_w), .op(op_w), .a(a_w), .b(b_w),
        .c_in(c_in_w), .dec(dec_w), .busy(busy_w), .done(done_w), .alu_out(alu_out_w),
        .alu_out_hi(alu_out_hi_w), .carry_out(carry_out_w), .half_carry_out(half_carry_out_w),
        .overflow_out(overflow_out_w), .zero_out(zero_out_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic dc);
        @(negedge clk);
        op = o; a = av; b = bv; c_in = ci; dec = dc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [7:0] r, input logic c,
                              input logic h, input logic v, input logic z);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_out"}, alu_out, r);
        check({tag, "_c"}, carry_out, c);
        check({tag, "_h"}, half_carry_out, h);
        check({tag, "_v"}, overflow_out, v);
        check({tag, "_z"}, zero_out, z);
    endtask

    initial begin
        int n_busy;
        int n_done;
        logic seen;

        reset_n = 1'b0; start = 1'b0; op = OP_PSA; a = '0; b = '0; c_in = 1'b0; dec = 1'b0;
        start_w = 1'b0; op_w = OP_PSA; a_w = '0; b_w = '0; c_in_w = 1'b0; dec_w = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", alu_out, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_hi", alu_out_hi, 8'h00);
        reset_n = 1'b1;

        issue(OP_ADC, 8'h19, 8'h28, 1'b0, 1'b1);
        expect_res("adc_dec_19_28", 8'h47, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("done_pulse_drop", done, 1'b0);
        check("hold_out", alu_out, 8'h47);

        issue(OP_ADC, 8'h99, 8'h01, 1'b0, 1'b1);
        expect_res("adc_dec_99_01", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(OP_ADC, 8'h7F, 8'h01, 1'b0, 1'b0);
        expect_res("adc_bin_7f_01", 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
        issue(OP_SBC, 8'h50, 8'h01, 1'b1, 1'b1);
        check("sbc_dec_50_01_out", alu_out, 8'h49);
        check("sbc_dec_50_01_c", carry_out, 1'b1);
        issue(OP_SBC, 8'h00, 8'h01, 1'b1, 1'b0);
        expect_res("sbc_bin_00_01", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(OP_AND, 8'hF0, 8'h3C, 1'b0, 1'b0);
        expect_res("and_nz", 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(OP_AND, 8'hF0, 8'h0F, 1'b1, 1'b0);
        expect_res("and_z", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(OP_ORA, 8'h12, 8'h40, 1'b0, 1'b0);
        expect_res("ora", 8'h52, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(OP_EOR, 8'hFF, 8'h0F, 1'b0, 1'b0);
        expect_res("eor", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(OP_TST, 8'h0F, 8'hFF, 1'b0, 1'b0);
        expect_res("tst", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(OP_ROR, 8'h02, 8'h00, 1'b0, 1'b0);
        expect_res("ror_c0", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'hF, 8'h5A, 8'h33, 1'b1, 1'b0);
        expect_res("undef_op", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_idle", alu_out, 8'h5A);

`ifdef ALU_SEQ_MUL_EN
        issue(OP_MUL, 8'h0F, 8'h11, 1'b0, 1'b0);
        check("mul_accept_done", done, 1'b0);
        n_busy = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (busy) n_busy++;
            if (done) seen = 1'b1;
            else begin
                if (i == 1) begin
                    start = 1'b1; op = OP_ADC; a = 8'h01; b = 8'h01;
                end
                if (i == 2) start = 1'b0;
                @(negedge clk);
            end
        end
        check("mul_done_seen", seen, 1'b1);
        check("mul_busy_cycles", n_busy, 8);
        check("mul_out", alu_out, 8'hFF);
        check("mul_hi", alu_out_hi, 8'h00);
        check("mul_c", carry_out, 1'b0);
        check("mul_z", zero_out, 1'b0);
        @(negedge clk);
        check("mul_no_extra_done", done, 1'b0);
        check("mul_hold", alu_out, 8'hFF);

        issue(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        check("mul_ff_out", alu_out, 8'h01);
        check("mul_ff_hi", alu_out_hi, 8'hFE);
        check("mul_ff_c", carry_out, 1'b1);

        issue(OP_ADC, 8'h01, 8'h01, 1'b0, 1'b0);
        check("hi_clear_after_adc", alu_out_hi, 8'h00);
        issue(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);

        issue(OP_MUL, 8'h0F, 8'h11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_mul_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_out", alu_out, 8'h00);
        check("async_rst_hi", alu_out_hi, 8'h00);
        check("async_rst_c", carry_out, 1'b0);
`else
        issue(OP_MUL, 8'h34, 8'h02, 1'b0, 1'b0);
        expect_res("mul_as_psa", 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mul_as_psa_busy", busy, 1'b0);
        check("mul_as_psa_hi", alu_out_hi, 8'h00);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_rst_out", alu_out, 8'h00);
        check("async_rst_busy", busy, 1'b0);
`endif
        check("async_rst_done", done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("no_done_after_abort", n_done, 0);

        issue(OP_ROR, 8'h01, 8'h00, 1'b1, 1'b0);
        expect_res("ror_after_rst", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        op_w = OP_ADC; a_w = 16'h0999; b_w = 16'h0001; c_in_w = 1'b0; dec_w = 1'b1; start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        check("w16_adc_done", done_w, 1'b1);
        check("w16_adc_out", alu_out_w, 16'h1000);
        check("w16_adc_c", carry_out_w, 1'b0);

        @(negedge clk);
        op_w = OP_MUL; a_w = 16'h1234; b_w = 16'h0010; dec_w = 1'b0; start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        check("w16_mul_busy", busy_w, 1'b1);
        for (int i = 0; i < 60 && !done_w; i++) @(negedge clk);
        check("w16_mul_done", done_w, 1'b1);
        check("w16_mul_out", alu_out_w, 16'h2340);
        check("w16_mul_hi", alu_out_hi_w, 16'h0001);
        check("w16_mul_c", carry_out_w, 1'b1);
`else
        check("w16_mul_psa_done", done_w, 1'b1);
        check("w16_mul_psa_out", alu_out_w, 16'h1234);
        check("w16_mul_psa_busy", busy_w, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
